mem_ring_arbiter: RTL

Round-robin request arbiter sharing one circular memory unit request port between up to four cache controllers (e.g. instruction and data cache). It captures one request packet at a time into a holding register and drives it onto the ring until the ring accepts it. It tags the packet's id with the source index and routes returning response packets back to the originating requester. It also caps outstanding packets per requester so that no controller can monopolise the ring.

---
 rtl/mem_ring_arbiter.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ring_arbiter.sv
// -----------------------------------------------------------------------------
// mem_ring_arbiter
//
// Shares one ring request port between NUM_REQ cache controllers. One request
// at a time is captured into the output holding registers and held until the
// ring accepts it. The source index is folded into id bits [3:2] so that
// returning responses can be routed back. Each requester is limited to
// MAX_OUT packets in flight.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                          undefined -> round-robin starting at rr_ptr
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_packet_type/id/addr/data   per-requester request (type 000 = idle)
//   req_ack                  one-cycle capture pulse per requester
//   packet_type_out/id_out/addr_out/data_out   packet to ring request port
//   ring_stall               ring cannot take the packet this cycle
//   packet_type_in/id_in/addr_in/data_in       response packet from ring
//   resp_packet_type         routed response type per requester (000 = none)
//   resp_id/resp_addr/resp_data                shared response fields
//   err_unexpected           sticky unroutable/unsolicited response flag
// -----------------------------------------------------------------------------
module mem_ring_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int MAX_OUT = 2,
    parameter int ADDR_W  = 36,
    parameter int DATA_W  = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0][2:0]        req_packet_type,
    input  logic [NUM_REQ-1:0][3:0]        req_id,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [2:0]                     packet_type_out,
    output logic [3:0]                     id_out,
    output logic [ADDR_W-1:0]              addr_out,
    output logic [DATA_W-1:0]              data_out,
    input  logic                           ring_stall,
    input  logic [2:0]                     packet_type_in,
    input  logic [3:0]                     id_in,
    input  logic [ADDR_W-1:0]              addr_in,
    input  logic [DATA_W-1:0]              data_in,
    output logic [NUM_REQ-1:0][2:0]        resp_packet_type,
    output logic [3:0]                     resp_id,
    output logic [ADDR_W-1:0]              resp_addr,
    output logic [DATA_W-1:0]              resp_data,
    output logic                           err_unexpected
);

    // state | meaning
    // IDLE  | no packet held; capture the next eligible request
    // SEND  | packet held on the ring port until ring_stall is low
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic [NUM_REQ-1:0][1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]         ack_q, ack_d;
    logic [2:0]                 pkt_type_q, pkt_type_d;
    logic [3:0]                 pkt_id_q, pkt_id_d;
    logic [ADDR_W-1:0]          pkt_addr_q, pkt_addr_d;
    logic [DATA_W-1:0]          pkt_data_q, pkt_data_d;
    logic [NUM_REQ-1:0][2:0]    rsp_type_q, rsp_type_d;
    logic [3:0]                 rsp_id_q, rsp_id_d;
    logic [ADDR_W-1:0]          rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0]          rsp_data_q, rsp_data_d;
    logic                       err_q, err_d;

    logic [NUM_REQ-1:0]         eligible;
    logic [NUM_REQ-1:0]         resp_hit;
    logic                       grant_vld;
    logic [1:0]                 grant_idx;
    logic [2:0]                 sel_type;
    logic [1:0]                 sel_id;
    logic [ADDR_W-1:0]          sel_addr;
    logic [DATA_W-1:0]          sel_data;
    logic                       capture;

    // Only the low two id bits travel with the packet.
    logic [NUM_REQ-1:0]         unused_req_id_hi;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign eligible[g] = (req_packet_type[g] != 3'd0) &&
                             (cnt_q[g] < 2'(MAX_OUT));
        assign resp_hit[g] = (packet_type_in != 3'd0) &&
                             (id_in[3:2] == 2'(g)) &&
                             (cnt_q[g] != 2'd0);
        assign unused_req_id_hi[g] = ^req_id[g][3:2];
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && eligible[i]) begin
                grant_vld = 1'b1;
                grant_idx = 2'(i);
            end
        end
    end
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;

    // First pass searches indices at or above rr_ptr; the second pass only
    // matters when nothing was found there, which is the wrap-around case.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && eligible[i] && (2'(i) >= rr_ptr_q)) begin
                grant_vld = 1'b1;
                grant_idx = 2'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && eligible[i]) begin
                grant_vld = 1'b1;
                grant_idx = 2'(i);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (capture) begin
            rr_ptr_d = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        sel_type = 3'd0;
        sel_id   = 2'd0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 2'(i)) begin
                sel_type = req_packet_type[i];
                sel_id   = req_id[i][1:0];
                sel_addr = req_addr[i];
                sel_data = req_data[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        pkt_type_d = pkt_type_q;
        pkt_id_d   = pkt_id_q;
        pkt_addr_d = pkt_addr_q;
        pkt_data_d = pkt_data_q;
        rsp_type_d = '0;
        rsp_id_d   = rsp_id_q;
        rsp_addr_d = rsp_addr_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        capture    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    capture    = 1'b1;
                    state_d    = ST_SEND;
                    pkt_type_d = sel_type;
                    pkt_id_d   = {grant_idx, sel_id};
                    pkt_addr_d = sel_addr;
                    pkt_data_d = sel_data;
                end
            end
            ST_SEND: begin
                if (!ring_stall) begin
                    pkt_type_d = 3'd0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (resp_hit != '0) begin
            rsp_id_d   = {2'b00, id_in[1:0]};
            rsp_addr_d = addr_in;
            rsp_data_d = data_in;
        end else if (packet_type_in != 3'd0) begin
            err_d = 1'b1;
        end

        // A capture and a response for the same requester cancel out.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (resp_hit[i]) begin
                rsp_type_d[i] = packet_type_in;
            end
            if (capture && (grant_idx == 2'(i))) begin
                ack_d[i] = 1'b1;
                if (!resp_hit[i]) begin
                    cnt_d[i] = cnt_q[i] + 2'd1;
                end
            end else if (resp_hit[i]) begin
                cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_q      <= '0;
            pkt_type_q <= 3'd0;
            pkt_id_q   <= 4'd0;
            pkt_addr_q <= '0;
            pkt_data_q <= '0;
            rsp_type_q <= '0;
            rsp_id_q   <= 4'd0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            pkt_type_q <= pkt_type_d;
            pkt_id_q   <= pkt_id_d;
            pkt_addr_q <= pkt_addr_d;
            pkt_data_q <= pkt_data_d;
            rsp_type_q <= rsp_type_d;
            rsp_id_q   <= rsp_id_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign req_ack          = ack_q;
    assign packet_type_out  = pkt_type_q;
    assign id_out           = pkt_id_q;
    assign addr_out         = pkt_addr_q;
    assign data_out         = pkt_data_q;
    assign resp_packet_type = rsp_type_q;
    assign resp_id          = rsp_id_q;
    assign resp_addr        = rsp_addr_q;
    assign resp_data        = rsp_data_q;
    assign err_unexpected   = err_q;

endmodule
